// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : irq_pkg
// Description : Shared widths, mask reset value, handshake FSM states and a
//               one-hot helper for the interrupt pending-capture block.
// Revision    : 1.0  initial release
// ============================================================================
package irq_pkg;

  localparam int IRQ_W  = 8;
  localparam int CODE_W = 3;

  // Every line is enabled out of reset.
  localparam logic [IRQ_W-1:0] MASK_RST = 8'hFF;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_e;

  // One-hot decode of a serviced line index.
  function automatic logic [IRQ_W-1:0] code_onehot(input logic [CODE_W-1:0] code);
    logic [IRQ_W-1:0] w_one;
    w_one = {{(IRQ_W-1){1'b0}}, 1'b1};
    return w_one << code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/irq_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : irq_sync_edge
// Description : Per-line SYNC_STAGES flop synchronizer followed by an edge
//               register; produces a one-cycle pulse for each rising edge.
// Ports       : clk, rst_n   - clock, asynchronous active-low reset
//               irq_i [IRQ_W] - asynchronous request lines
//               edge_o[IRQ_W] - rising-edge pulses (sync & ~prev)
// Revision    : 1.0  initial release
// ============================================================================
module irq_sync_edge
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2   // must be at least 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IRQ_W-1:0] irq_i,
  output logic [IRQ_W-1:0] edge_o
);

  logic [IRQ_W-1:0] sync_q [SYNC_STAGES];
  logic [IRQ_W-1:0] prev_q;

  // Everything resets to 0, so a line held high across reset release
  // is reported as exactly one rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      prev_q <= '0;
    end else begin
      sync_q[0] <= irq_i;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/irq_pending_capture.sv
`default_nettype none
// ============================================================================
// Module      : irq_pending_capture
// Description : Captures rising edges on eight asynchronous request lines as
//               sticky pending bits, presents a frozen masked snapshot to the
//               priority encoder with a valid/ack handshake, and clears the
//               serviced bit named by the returned code.
// Ports       : clk, rst_n           - clock, asynchronous active-low reset
//               irq_in[8]            - asynchronous request lines
//               mask_wr, mask_data   - mask load strobe and value (1=enable)
//               mask_q[8], pend_q[8] - current mask, raw pending bits
//               req_vec[8], req_valid- frozen snapshot and its valid flag
//               req_ack, ack_code[3] - consumer handshake and serviced index
//               ovf_q[8], bad_ack    - sticky lost-event / bad-ack flags
//               ovf_clr              - clears ovf_q and bad_ack
// Revision    : 1.0  initial release
// ============================================================================
module irq_pending_capture
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IRQ_W-1:0]  irq_in,
  input  logic              mask_wr,
  input  logic [IRQ_W-1:0]  mask_data,
  output logic [IRQ_W-1:0]  mask_q,
  output logic [IRQ_W-1:0]  pend_q,
  output logic [IRQ_W-1:0]  req_vec,
  output logic              req_valid,
  input  logic              req_ack,
  input  logic [CODE_W-1:0] ack_code,
  output logic [IRQ_W-1:0]  ovf_q,
  output logic              bad_ack,
  input  logic              ovf_clr
);

  state_e           state_q, state_d;
  logic [IRQ_W-1:0] req_vec_q, req_vec_d;
  logic [IRQ_W-1:0] pend_d;
  logic [IRQ_W-1:0] mask_d;
  logic [IRQ_W-1:0] ovf_d;
  logic             bad_ack_q, bad_ack_d;

  logic [IRQ_W-1:0] w_edge;
  logic [IRQ_W-1:0] w_clr;
  logic             w_bad_set;
  logic [IRQ_W-1:0] w_ovf_set;

  irq_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .irq_i  (irq_in),
    .edge_o (w_edge)
  );

  // --------------------------------------------------------------------------
  // Handshake FSM: snapshot is taken from registered pend/mask, so a mask
  // write or new event during PRESENT only affects the next snapshot, and
  // valid always drops for at least one cycle after an ack.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    req_vec_d = req_vec_q;
    w_clr     = '0;
    w_bad_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (|(pend_q & mask_q)) begin
          req_vec_d = pend_q & mask_q;
          state_d   = PRESENT;
        end
      end
      PRESENT: begin
        if (req_ack) begin
          if (req_vec_q[ack_code]) begin
            w_clr = code_onehot(ack_code);
          end else begin
            w_bad_set = 1'b1;
          end
          req_vec_d = '0;
          state_d   = IDLE;
        end
      end
      default: begin
        req_vec_d = '0;
        state_d   = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Pending / overflow / mask next state. A new edge always wins over a
  // same-cycle clear; it only counts as lost when the bit stays pending.
  // --------------------------------------------------------------------------
  always_comb begin
    w_ovf_set = w_edge & pend_q & ~w_clr;
    pend_d    = (pend_q & ~w_clr) | w_edge;
    ovf_d     = ovf_clr ? w_ovf_set : (ovf_q | w_ovf_set);
    bad_ack_d = ovf_clr ? w_bad_set : (bad_ack_q | w_bad_set);
    mask_d    = mask_wr ? mask_data : mask_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      req_vec_q <= '0;
      pend_q    <= '0;
      ovf_q     <= '0;
      bad_ack_q <= 1'b0;
      mask_q    <= MASK_RST;
    end else begin
      state_q   <= state_d;
      req_vec_q <= req_vec_d;
      pend_q    <= pend_d;
      ovf_q     <= ovf_d;
      bad_ack_q <= bad_ack_d;
      mask_q    <= mask_d;
    end
  end

  assign req_vec   = req_vec_q;
  assign req_valid = (state_q == PRESENT);
  assign bad_ack   = bad_ack_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_pending_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_pending_capture
// Description : Scoreboard bench. The driver advances a behavioural model
//               once per clock and queues the expected post-edge outputs; a
//               monitor pops and compares them just after each rising edge.
// Revision    : 1.0  initial release
// ============================================================================
module tb_irq_pending_capture;

  logic       clk;
  logic       rst_n;
  logic [7:0] irq_in;
  logic       mask_wr;
  logic [7:0] mask_data;
  logic [7:0] mask_q;
  logic [7:0] pend_q;
  logic [7:0] req_vec;
  logic       req_valid;
  logic       req_ack;
  logic [2:0] ack_code;
  logic [7:0] ovf_q;
  logic       bad_ack;
  logic       ovf_clr;

  irq_pending_capture #(.SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_in    (irq_in),
    .mask_wr   (mask_wr),
    .mask_data (mask_data),
    .mask_q    (mask_q),
    .pend_q    (pend_q),
    .req_vec   (req_vec),
    .req_valid (req_valid),
    .req_ack   (req_ack),
    .ack_code  (ack_code),
    .ovf_q     (ovf_q),
    .bad_ack   (bad_ack),
    .ovf_clr   (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] pend;
    logic [7:0] mask;
    logic [7:0] vec;
    logic [7:0] ovf;
    logic       valid;
    logic       bad;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Behavioural model: a rising edge sampled on irq_in at clock n becomes a
  // pending event at clock n+2; a presentation is a frozen copy of
  // pending&mask that lasts until acknowledged.
  logic [7:0] s1, s2, s3;          // irq_in samples from 1, 2, 3 clocks ago
  logic [7:0] m_pend, m_mask, m_vec, m_ovf;
  logic       m_valid, m_bad;

  task automatic model_reset();
    s1 = 0; s2 = 0; s3 = 0;
    m_pend = 0; m_mask = 8'hFF; m_vec = 0; m_ovf = 0;
    m_valid = 0; m_bad = 0;
  endtask

  task automatic model_step();
    logic [7:0] ev, clr, lost, n_pend, n_vec;
    logic       badhit, n_valid;
    ev     = s2 & ~s3;
    clr    = 0;
    badhit = 0;
    if (m_valid && req_ack) begin
      if (m_vec[ack_code]) clr[ack_code] = 1'b1;
      else badhit = 1'b1;
    end
    lost   = ev & m_pend & ~clr;
    n_pend = (m_pend & ~clr) | ev;
    n_valid = m_valid;
    n_vec   = m_vec;
    if (m_valid) begin
      if (req_ack) begin n_valid = 0; n_vec = 0; end
    end else if ((m_pend & m_mask) != 0) begin
      n_valid = 1; n_vec = m_pend & m_mask;
    end
    m_ovf  = ovf_clr ? lost : (m_ovf | lost);
    m_bad  = ovf_clr ? badhit : (m_bad | badhit);
    m_mask = mask_wr ? mask_data : m_mask;
    m_pend = n_pend;
    m_valid = n_valid;
    m_vec   = n_vec;
    s3 = s2; s2 = s1; s1 = irq_in;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Monitor: compares the DUT just after each active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pend_q",    pend_q,            e.pend);
        check("mask_q",    mask_q,            e.mask);
        check("req_vec",   req_vec,           e.vec);
        check("req_valid", {7'd0, req_valid}, {7'd0, e.valid});
        check("ovf_q",     ovf_q,             e.ovf);
        check("bad_ack",   {7'd0, bad_ack},   {7'd0, e.bad});
      end
    end
  end

  // One clock of stimulus; called at a falling edge, returns at the next one.
  task automatic cycle(input logic [7:0] irq, input logic mwr, input logic [7:0] mdat,
                       input logic ack, input logic [2:0] code, input logic oclr);
    irq_in = irq; mask_wr = mwr; mask_data = mdat;
    req_ack = ack; ack_code = code; ovf_clr = oclr;
    model_step();
    exp_q.push_back('{m_pend, m_mask, m_vec, m_ovf, m_valid, m_bad});
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic [7:0] irq);
    for (int i = 0; i < n; i++) cycle(irq, 0, 8'h00, 0, 3'd0, 0);
  endtask

  task automatic ack(input logic [2:0] code);
    cycle(8'h00, 0, 8'h00, 1, code, 0);
  endtask

  task automatic wait_model_valid(input string name);
    int k;
    k = 0;
    while (!m_valid && k < 20) begin idle(1, 8'h00); k++; end
    n_total++;
    if (m_valid) n_pass++;
    else $display("FAIL %s: no presentation within %0d cycles (got 0, expected 1)", name, k);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " req_vec"},   req_vec,           8'h00);
    check({tag, " req_valid"}, {7'd0, req_valid}, 8'h00);
    check({tag, " pend_q"},    pend_q,            8'h00);
    check({tag, " ovf_q"},     ovf_q,             8'h00);
    check({tag, " bad_ack"},   {7'd0, bad_ack},   8'h00);
    check({tag, " mask_q"},    mask_q,            8'hFF);
  endtask

  initial begin
    int unsigned r;
    logic [7:0] irq_r, mdat_r;
    logic [2:0] code_r;
    logic       ack_r, mwr_r, clr_r;

    rst_n = 0; irq_in = 0; mask_wr = 0; mask_data = 0;
    req_ack = 0; ack_code = 0; ovf_clr = 0;
    model_reset();
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1;

    // Single event on line 5.
    cycle(8'h20, 0, 8'h00, 0, 3'd0, 0);
    idle(3, 8'h00);
    ack(3'd5);
    idle(2, 8'h00);
    cycle(8'h00, 0, 8'h00, 1, 3'd2, 0);   // ack while idle is ignored

    // Lines 2 and 6 together.
    cycle(8'h44, 0, 8'h00, 0, 3'd0, 0);
    wait_model_valid("multi first");
    ack(3'd2);
    idle(1, 8'h00);
    wait_model_valid("multi second");
    ack(3'd6);
    idle(2, 8'h00);

    // Masking of line 0.
    cycle(8'h00, 1, 8'hFE, 0, 3'd0, 0);
    cycle(8'h01, 0, 8'h00, 0, 3'd0, 0);
    idle(4, 8'h00);
    cycle(8'h00, 1, 8'hFF, 0, 3'd0, 0);
    idle(2, 8'h00);
    wait_model_valid("mask reenable");
    ack(3'd0);
    idle(1, 8'h00);

    // Overflow on line 3, then edge colliding with its ack-clear.
    cycle(8'h08, 0, 8'h00, 0, 3'd0, 0);
    wait_model_valid("ovf present");
    cycle(8'h00, 0, 8'h00, 0, 3'd0, 0);
    cycle(8'h08, 0, 8'h00, 0, 3'd0, 0);
    idle(3, 8'h08);
    cycle(8'h00, 0, 8'h00, 0, 3'd0, 0);
    cycle(8'h08, 0, 8'h00, 0, 3'd0, 0);
    cycle(8'h08, 0, 8'h00, 0, 3'd0, 0);
    cycle(8'h08, 0, 8'h00, 1, 3'd3, 0);
    idle(3, 8'h00);
    ack(3'd3);
    cycle(8'h00, 0, 8'h00, 0, 3'd0, 1);
    idle(2, 8'h00);

    // Bad ack.
    cycle(8'h10, 0, 8'h00, 0, 3'd0, 0);
    wait_model_valid("bad present");
    ack(3'd1);
    idle(2, 8'h00);
    wait_model_valid("bad re-present");
    ack(3'd4);
    cycle(8'h00, 0, 8'h00, 0, 3'd0, 1);

    // Reset in the middle of a presentation.
    cycle(8'h02, 1, 8'h3C, 0, 3'd0, 0);
    cycle(8'h00, 1, 8'hFF, 0, 3'd0, 0);
    wait_model_valid("pre-reset present");
    cycle(8'h00, 1, 8'h5A, 0, 3'd0, 0);
    @(posedge clk);
    #3;
    check("pre-reset req_valid", {7'd0, req_valid}, {7'd0, m_valid});
    rst_n = 0;
    #1;
    check_reset_values("async reset");
    model_reset();
    irq_in = 8'h80;                       // held high across release
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    idle(4, 8'h80);
    wait_model_valid("held-through-reset");
    ack(3'd7);
    idle(2, 8'h00);

    // Randomized traffic.
    irq_r = 0;
    for (int i = 0; i < 600; i++) begin
      r = $urandom;
      if (r[1:0] == 2'd0) irq_r[r[4:2]] = ~irq_r[r[4:2]];
      ack_r  = 0;
      code_r = 3'($urandom_range(0, 7));
      if (m_valid && ($urandom_range(0, 2) == 0)) begin
        ack_r = 1;
        if ($urandom_range(0, 4) != 0) begin
          for (int b = 7; b >= 0; b--) if (m_vec[b]) code_r = 3'(b);
        end
      end else if (!m_valid && ($urandom_range(0, 15) == 0)) begin
        ack_r = 1;
      end
      mwr_r  = ($urandom_range(0, 19) == 0);
      mdat_r = 8'($urandom);
      clr_r  = ($urandom_range(0, 24) == 0);
      cycle(irq_r, mwr_r, mdat_r, ack_r, code_r, clr_r);
    end
    idle(3, irq_r);

    #2;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/irq_pending_capture.md
# irq_pending_capture

Upstream stage of the 8-input priority encoder. Synchronizes eight asynchronous interrupt request lines, detects rising edges, and holds them as sticky pending bits under a software mask. It presents a stable masked snapshot (`req_vec`) with a valid/ack handshake to the encoder. The encoder's 3-bit code returns on `ack_code`, and this block clears the serviced pending bit.

## Interface
- `IRQ_W`, 8: number of request lines. Fixed at 8 to match the encoder.
- `CODE_W`, 3: width of `ack_code`, equal to clog2(`IRQ_W`).
- `SYNC_STAGES`, 2: synchronizer depth, minimum 2.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous reset, active-low.
- `irq_in` in 8: asynchronous request lines, rising-edge significant.
- `mask_wr` in 1: load `mask_data` into the mask register.
- `mask_data` in 8: new mask; 1 = enabled.
- `mask_q` out 8: current mask.
- `pend_q` out 8: raw pending bits, unmasked.
- `req_vec` out 8: masked snapshot feeding the encoder `in`.
- `req_valid` out 1: `req_vec` is valid and held stable.
- `req_ack` in 1: consumer has taken the request.
- `ack_code` in 3: index being serviced, qualified by `req_ack`.
- `ovf_q` out 8: sticky lost-event flags, one per line.
- `bad_ack` out 1: sticky; set on an ack whose `ack_code` is not set in `req_vec`.
- `ovf_clr` in 1: clears `ovf_q` and `bad_ack`.

## Operation
- Each `irq_in[i]` passes through `SYNC_STAGES` flops, then an edge register. `edge[i]` = sync & ~prev.
- `edge[i]` sets `pend[i]`. Masked-off lines still accumulate pending; the mask only gates the snapshot.
- If `edge[i]` arrives while `pend[i]` is already 1 and `pend[i]` is not being cleared that cycle, set `ovf[i]`.
- FSM states:
  - IDLE: `req_valid`=0. If (`pend` & `mask`) != 0, load `req_vec` <= `pend` & `mask` and go to PRESENT.
  - PRESENT: `req_valid`=1 and `req_vec` frozen. On `req_ack`:
    - If `req_vec[ack_code]`=1, clear `pend[ack_code]`.
    - Otherwise clear nothing and set `bad_ack`.
    - Go to IDLE.
- Same-cycle clear of `pend[k]` and `edge[k]`: the set wins, the event stays pending, and `ovf[k]` is not set.
- `mask_wr` updates `mask_q` on the next edge. In PRESENT it does not alter `req_vec`; it affects the next snapshot only.
- `ovf_clr` together with a new overflow event on the same cycle: the set wins.
- `req_vec` is 0 whenever `req_valid`=0. The encoder never sees the all-zero vector while valid.

## Timing
- Reset values:
  - `req_vec`=0, `req_valid`=0, `pend_q`=0, `ovf_q`=0, `bad_ack`=0, `mask_q`=8'hFF, FSM=IDLE.
  - Synchronizer and edge flops reset to 0. A line held high through reset release therefore produces one event.
- Latency: `irq_in[i]` rises before clock edge E0.
  - Sync stage 2 is high after E1 (with `SYNC_STAGES`=2).
  - `pend_q[i]` is set at E2.
  - `req_valid` rises at E3 if enabled and FSM is IDLE.
- Ack: `req_ack` is sampled at edge A.
  - `pend` clears at A; `req_valid` falls at A.
  - `req_valid` stays low for a minimum of one cycle.
  - If pending remains, the next snapshot is presented at A+1.
- `req_ack` while `req_valid`=0 is ignored: no clear, no flag.
- Reset asserted mid-handshake: all state returns to reset values immediately. The pending request is lost.

## Structure
- Package `irq_pkg` holds:
  - `IRQ_W`=8 and `CODE_W`=3.
  - The FSM state enum {IDLE, PRESENT}.
  - Mask reset constant `MASK_RST`=8'hFF.
- Sub-module `irq_sync_edge`: a vector `SYNC_STAGES` synchronizer plus edge register, outputting an `IRQ_W`-bit edge pulse vector.
- The top level holds the pending, mask and overflow registers and the FSM.

## Test plan
- **Single event:** pulse `irq_in[5]` after reset → `pend_q`=8'h20 at E2; `req_valid`=1 and `req_vec`=8'h20 at E3. Ack with `ack_code`=5 → `pend_q`=0 and `req_valid`=0 next cycle.
- **Multiple pending:** raise lines 2 and 6 together → `req_vec`=8'h44. Ack code 2 → `req_valid` low one cycle, then `req_vec`=8'h40. Ack code 6 → idle.
- **Masking:** `mask_q`=8'hFE and pulse line 0 → `pend_q`=8'h01, `req_valid` stays 0. Write mask 8'hFF → `req_valid` after one cycle with `req_vec`=8'h01.
- **Overflow and collision:**
  - Second edge on line 3 while it is pending → `ovf_q`=8'h08.
  - Edge on line 3 in the same cycle as its ack-clear → `pend_q[3]` stays 1 and `ovf_q` is unchanged.
  - `ovf_clr` → 0.
- **Bad ack:** `req_vec`=8'h10 and ack with `ack_code`=1 → `bad_ack`=1, `pend_q` unchanged; re-presented with `req_vec`=8'h10.
- **Reset mid-PRESENT:** assert `rst_n`=0 while `req_valid`=1 → all outputs at reset values asynchronously; `mask_q`=8'hFF.
